// File: rtl/memory_arbiter_pkg.sv
// Shared types and helpers for the main_memory Port B arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int LINE_BYTES = 16;

  function automatic int beat_cnt_w(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

  // Byte-offset bits inside one line; cleared to find the burst base.
  function automatic logic [31:0] word_off_mask(input int line_words);
    return 32'(line_words * 4 - 1);
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester and main_memory Port B signals of the arbiter, grouped as one bus.
interface memory_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  // Requests: req_valid is held until the single-cycle req_ready pulse for
  // that master; responses carry no backpressure and must always be sunk.
  logic [NUM_MASTERS-1:0]    req_valid;
  logic [NUM_MASTERS-1:0]    req_ready;
  logic [NUM_MASTERS-1:0]    req_write;
  logic [NUM_MASTERS-1:0]    req_burst;
  logic [NUM_MASTERS*32-1:0] req_addr;
  logic [NUM_MASTERS*32-1:0] req_wdata;
  logic [NUM_MASTERS*4-1:0]  req_byte_en;
  logic [NUM_MASTERS-1:0]    resp_valid;
  logic [31:0]               resp_rdata;
  logic                      resp_last;
  logic [31:0]               mem_address;
  logic [31:0]               mem_write_data;
  logic                      mem_write_enable;
  logic [3:0]                mem_byte_enable;
  logic [31:0]               mem_read_data;

  modport slave (
    input  req_valid, req_write, req_burst, req_addr, req_wdata, req_byte_en,
    input  mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_last,
    output mem_address, mem_write_data, mem_write_enable, mem_byte_enable
  );

  modport master (
    output req_valid, req_write, req_burst, req_addr, req_wdata, req_byte_en,
    output mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_last,
    input  mem_address, mem_write_data, mem_write_enable, mem_byte_enable
  );

endinterface

// File: rtl/memory_arbiter_rr_arbiter.sv
// Combinational pick of the first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int off = 0; off < N; off++) begin
      cand = (int'(ptr) + off) % N;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing main_memory Port B; define MEM_ARB_FIXED_PRIO_EN
// for lowest-index-wins priority instead of round-robin.
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int LINE_WORDS  = LINE_BYTES / 4
) (
  input  logic                clk,
  input  logic                rst_n,
  memory_arbiter_if.slave     bus,
  output state_t              fsm_state
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = beat_cnt_w(LINE_WORDS);
  localparam logic [31:0] LINE_MASK = word_off_mask(LINE_WORDS);

  state_t state, state_nx;

  logic [IW-1:0]          rr_ptr, arb_ptr, win_idx, cur_idx;
  logic [NUM_MASTERS-1:0] win_grant;
  logic                   win_any;
  logic [CW-1:0]          beat;
  logic                   cur_write, cur_burst;
  logic [31:0]            cur_base, cur_wdata;
  logic [3:0]             cur_be;
  logic                   grant_now, last_beat;
  logic [31:0]            sel_addr;
  logic                   sel_write, sel_burst;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  assign arb_ptr = rr_ptr;
`endif

  rr_arbiter #(.N(NUM_MASTERS)) u_arb (
    .req   (bus.req_valid),
    .ptr   (arb_ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign grant_now = (state == IDLE) && win_any;
  assign last_beat = (state == ACCESS) &&
                     (!cur_burst || (beat == CW'(LINE_WORDS - 1)));
  assign sel_addr  = bus.req_addr[32*win_idx +: 32];
  assign sel_write = bus.req_write[win_idx];
  assign sel_burst = bus.req_burst[win_idx] & ~sel_write;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (win_any)   state_nx = ACCESS;
      ACCESS:  if (last_beat) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory port is driven only while a beat is in flight, so an async reset
  // drops the write enable at once.
  always_comb begin
    bus.req_ready        = grant_now ? win_grant : '0;
    bus.mem_address      = '0;
    bus.mem_write_data   = '0;
    bus.mem_write_enable = 1'b0;
    bus.mem_byte_enable  = '0;
    if (state == ACCESS) begin
      bus.mem_address = cur_base + (32'(beat) << 2);
      if (cur_write) begin
        bus.mem_write_data   = cur_wdata;
        bus.mem_write_enable = 1'b1;
        bus.mem_byte_enable  = cur_be;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      cur_idx   <= '0;
      cur_write <= 1'b0;
      cur_burst <= 1'b0;
      cur_base  <= '0;
      cur_wdata <= '0;
      cur_be    <= '0;
      beat      <= '0;
    end else if (grant_now) begin
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_ptr    <= (win_idx == IW'(NUM_MASTERS - 1)) ? '0 : win_idx + 1'b1;
`endif
      cur_idx   <= win_idx;
      cur_write <= sel_write;
      cur_burst <= sel_burst;
      cur_base  <= sel_burst ? (sel_addr & ~LINE_MASK) : (sel_addr & ~32'd3);
      cur_wdata <= bus.req_wdata[32*win_idx +: 32];
      cur_be    <= bus.req_byte_en[4*win_idx +: 4];
      beat      <= '0;
    end else if (state == ACCESS) begin
      beat <= beat + 1'b1;
    end
  end

  // One registered response per beat; write beats return zero data as an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.resp_valid <= '0;
      bus.resp_rdata <= '0;
      bus.resp_last  <= 1'b0;
    end else if (state == ACCESS) begin
      bus.resp_valid <= NUM_MASTERS'(1) << cur_idx;
      bus.resp_rdata <= cur_write ? 32'd0 : bus.mem_read_data;
      bus.resp_last  <= last_beat;
    end else begin
      bus.resp_valid <= '0;
      bus.resp_rdata <= '0;
      bus.resp_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a small word-addressed memory model.
module tb_memory_arbiter;
  import mem_arb_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t fsm_state;
  int     total;
  int     bad;

  logic [31:0] mem_model [0:1023];
  logic [3:0]  got [0:4];
  logic [3:0]  exp_g [0:4];
  int          ngot;

  memory_arbiter_if #(.NUM_MASTERS(4)) bus ();

  memory_arbiter #(.NUM_MASTERS(4), .LINE_WORDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .fsm_state (fsm_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign bus.mem_read_data = mem_model[bus.mem_address[11:2]];

  always @(posedge clk) begin
    if (bus.mem_write_enable) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_byte_enable[b])
          mem_model[bus.mem_address[11:2]][8*b +: 8] = bus.mem_write_data[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int m, input logic wr, input logic bu, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
    bus.req_valid[m]           = 1'b1;
    bus.req_write[m]           = wr;
    bus.req_burst[m]           = bu;
    bus.req_addr[32*m +: 32]   = addr;
    bus.req_wdata[32*m +: 32]  = wd;
    bus.req_byte_en[4*m +: 4]  = be;
  endtask

  task automatic clr_req(input int m);
    bus.req_valid[m] = 1'b0;
  endtask

  task automatic after_pos();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 1024; i++) mem_model[i] = 32'hA5A5_0000 | 32'(i);
    mem_model[32'h41] = 32'hDEAD_BEEF;
    mem_model[32'h04] = 32'hAABB_CCDD;
    mem_model[32'h08] = 32'h1234_5678;
    for (int k = 0; k < 4; k++) mem_model[32'h80 + k] = 32'hB000_0000 + 32'(k);
    for (int k = 0; k < 4; k++) mem_model[32'hC0 + k] = 32'hC000_0000 + 32'(k);
    mem_model[32'h11] = 32'h4444_0011;
    bus.req_valid   = '0;
    bus.req_write   = '0;
    bus.req_burst   = '0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.req_byte_en = '0;

    // Reset values
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(fsm_state), 32'(IDLE));
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_resp_last", 32'(bus.resp_last), 32'h0);
    chk("rst_mem_we", 32'(bus.mem_write_enable), 32'h0);
    chk("rst_mem_addr", bus.mem_address, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single read, M1 @0x104
    after_pos();
    set_req(1, 1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0);
    @(negedge clk);
    chk("t1_ready", 32'(bus.req_ready), 32'h2);
    after_pos();
    clr_req(1);
    @(negedge clk);
    chk("t1_addr", bus.mem_address, 32'h0000_0104);
    chk("t1_we", 32'(bus.mem_write_enable), 32'h0);
    chk("t1_no_early_resp", 32'(bus.resp_valid), 32'h0);
    @(negedge clk);
    chk("t1_resp_valid", 32'(bus.resp_valid), 32'h2);
    chk("t1_rdata", bus.resp_rdata, 32'hDEAD_BEEF);
    chk("t1_last", 32'(bus.resp_last), 32'h1);

    // Write with byte enables, M0 @0x10
    after_pos();
    set_req(0, 1'b1, 1'b0, 32'h0000_0010, 32'h1122_3344, 4'b0101);
    @(negedge clk);
    chk("t2_ready", 32'(bus.req_ready), 32'h1);
    after_pos();
    clr_req(0);
    @(negedge clk);
    chk("t2_we", 32'(bus.mem_write_enable), 32'h1);
    chk("t2_addr", bus.mem_address, 32'h0000_0010);
    chk("t2_wdata", bus.mem_write_data, 32'h1122_3344);
    chk("t2_be", 32'(bus.mem_byte_enable), 32'h5);
    @(negedge clk);
    chk("t2_we_off", 32'(bus.mem_write_enable), 32'h0);
    chk("t2_ack_valid", 32'(bus.resp_valid), 32'h1);
    chk("t2_ack_rdata", bus.resp_rdata, 32'h0);
    chk("t2_ack_last", 32'(bus.resp_last), 32'h1);
    chk("t2_mem", mem_model[32'h04], 32'hAA22_CC44);

    // Burst read, M2 @0x208 -> line 0x200
    after_pos();
    set_req(2, 1'b0, 1'b1, 32'h0000_0208, 32'h0, 4'h0);
    @(negedge clk);
    chk("t3_ready", 32'(bus.req_ready), 32'h4);
    after_pos();
    clr_req(2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t3_addr%0d", k), bus.mem_address, 32'h0000_0200 + 32'(4 * k));
      if (k > 0) begin
        chk($sformatf("t3_valid%0d", k - 1), 32'(bus.resp_valid), 32'h4);
        chk($sformatf("t3_rdata%0d", k - 1), bus.resp_rdata, 32'hB000_0000 + 32'(k - 1));
        chk($sformatf("t3_last%0d", k - 1), 32'(bus.resp_last), 32'h0);
      end
    end
    @(negedge clk);
    chk("t3_valid3", 32'(bus.resp_valid), 32'h4);
    chk("t3_rdata3", bus.resp_rdata, 32'hB000_0003);
    chk("t3_last3", 32'(bus.resp_last), 32'h1);
    chk("t3_idle", 32'(fsm_state), 32'(IDLE));

    // Back-to-back: M0 burst @0x300, then M3 single @0x44
    after_pos();
    set_req(0, 1'b0, 1'b1, 32'h0000_0300, 32'h0, 4'h0);
    @(negedge clk);
    chk("t5_ready_m0", 32'(bus.req_ready), 32'h1);
    after_pos();
    clr_req(0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t5_addr%0d", k), bus.mem_address, 32'h0000_0300 + 32'(4 * k));
      if (k == 3) begin
        after_pos();
        set_req(3, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 4'h0);
      end
    end
    @(negedge clk);
    chk("t5_ready_m3", 32'(bus.req_ready), 32'h8);
    chk("t5_m0_valid", 32'(bus.resp_valid), 32'h1);
    chk("t5_m0_last", 32'(bus.resp_last), 32'h1);
    chk("t5_m0_rdata", bus.resp_rdata, 32'hC000_0003);
    after_pos();
    clr_req(3);
    @(negedge clk);
    chk("t5_m3_addr", bus.mem_address, 32'h0000_0044);
    @(negedge clk);
    chk("t5_m3_valid", 32'(bus.resp_valid), 32'h8);
    chk("t5_m3_rdata", bus.resp_rdata, 32'h4444_0011);

    // Reset in the middle of a write, M1 @0x20
    after_pos();
    set_req(1, 1'b1, 1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk);
    chk("t6_ready", 32'(bus.req_ready), 32'h2);
    after_pos();
    clr_req(1);
    @(negedge clk);
    chk("t6_we_on", 32'(bus.mem_write_enable), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_we_drop", 32'(bus.mem_write_enable), 32'h0);
    chk("t6_state", 32'(fsm_state), 32'(IDLE));
    @(negedge clk);
    chk("t6_mem", mem_model[32'h08], 32'h1234_5678);
    chk("t6_no_resp", 32'(bus.resp_valid), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_no_resp_after", 32'(bus.resp_valid), 32'h0);
    chk("t6_idle_after", 32'(fsm_state), 32'(IDLE));

    // Fairness with all four masters held valid (pointer is 0 after reset)
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_g[0] = 4'h1; exp_g[1] = 4'h1; exp_g[2] = 4'h1; exp_g[3] = 4'h1; exp_g[4] = 4'h1;
`else
    exp_g[0] = 4'h1; exp_g[1] = 4'h2; exp_g[2] = 4'h4; exp_g[3] = 4'h8; exp_g[4] = 4'h1;
`endif
    ngot = 0;
    after_pos();
    for (int m = 0; m < 4; m++) set_req(m, 1'b0, 1'b0, 32'(16 * m), 32'h0, 4'h0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.req_ready != 4'h0 && ngot < 5) begin
        got[ngot] = bus.req_ready;
        ngot++;
      end
    end
    after_pos();
    bus.req_valid = '0;
    chk("t4_count", 32'(ngot), 32'd5);
    for (int g = 0; g < 5; g++)
      chk($sformatf("t4_grant%0d", g), (g < ngot) ? 32'(got[g]) : 32'hFFFF_FFFF, 32'(exp_g[g]));
    repeat (3) @(negedge clk);
    chk("t4_drain_idle", 32'(fsm_state), 32'(IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
